// File: rtl/perf_pkg.sv
// Register map and control/command bit positions for the perf-counter bank.
// The address mux and the software headers use the same offsets.
package perf_pkg;

  localparam int unsigned CTRL      = 'h00;
  localparam int unsigned EN        = 'h01;
  localparam int unsigned OVF       = 'h02;
  localparam int unsigned OVF_IE    = 'h03;
  localparam int unsigned CMD       = 'h04;
  localparam int unsigned CYCLE     = 'h05;
  localparam int unsigned CNT_BASE  = 'h08;
  localparam int unsigned SNAP_BASE = 'h10;
  localparam int unsigned SNAP_CYC  = 'h18;

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_FREEZE = 1;
  localparam int unsigned CMD_CLEAR   = 0;
  localparam int unsigned CMD_SNAP    = 1;

endpackage

// File: rtl/perf_counter.sv
// 64-bit counter with clear > load > increment priority.
// wrap pulses in the cycle whose increment takes the count from all-ones to zero.
module perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        load,
  input  logic [63:0] load_val,
  input  logic        clr,
  output logic [63:0] count,
  output logic        wrap
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (inc)
      count <= count + 64'd1;
  end

  assign wrap = inc & ~clr & ~load & (&count);

endmodule

// File: rtl/perf_counter_bank.sv
// Memory-mapped performance-counter bank: event counters, cycle counter, overflow
// flags with interrupt, snapshot copies and a one-cycle registered read port.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int N_CNT  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       ain,
  input  logic [63:0]       din,
  input  logic              wren,
  output logic [63:0]       dout,
  input  logic [N_CNT-1:0]  events,
  output logic              irq
);

  logic [ADDR_W-1:0] addr;
  logic [1:0]        ctrl;
  logic [N_CNT-1:0]  en;
  logic [N_CNT:0]    ovf;
  logic [N_CNT:0]    ovf_ie;
  logic [N_CNT:0]    ovf_clr;
  logic [N_CNT:0]    wrap;
  logic [N_CNT:0]    inc;
  logic [N_CNT:0]    load;
  logic [63:0]       cnt  [N_CNT+1];
  logic [63:0]       snap [N_CNT+1];
  logic              run;
  logic              cmd_wr;
  logic              clr_all;
  logic              snap_now;
  logic [63:0]       rd_data;
  logic              unused_addr;

  assign addr        = ain[ADDR_W-1:0];
  assign unused_addr = ^ain[63:ADDR_W];
  assign run         = ctrl[CTRL_ENABLE] & ~ctrl[CTRL_FREEZE];
  assign cmd_wr      = wren && (addr == ADDR_W'(CMD));
  assign clr_all     = cmd_wr & din[CMD_CLEAR];
  assign snap_now    = cmd_wr & din[CMD_SNAP];
  assign ovf_clr     = (wren && (addr == ADDR_W'(OVF))) ? din[N_CNT:0] : '0;

  // Slot N_CNT of every per-counter vector/array is the free-running cycle counter.
  always_comb begin
    inc  = '0;
    load = '0;
    for (int i = 0; i < N_CNT; i++) begin
      inc[i]  = events[i] & en[i] & run;
      load[i] = wren && (addr == ADDR_W'(CNT_BASE + i));
    end
    inc[N_CNT]  = run;
    load[N_CNT] = wren && (addr == ADDR_W'(CYCLE));
  end

  for (genvar g = 0; g <= N_CNT; g++) begin : g_cnt
    perf_counter u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc[g]),
      .load     (load[g]),
      .load_val (din),
      .clr      (clr_all),
      .count    (cnt[g]),
      .wrap     (wrap[g])
    );
  end

  // A wrap in the same cycle as a W1C of that bit keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl   <= '0;
      en     <= '0;
      ovf_ie <= '0;
      ovf    <= '0;
      irq    <= 1'b0;
    end else begin
      if (wren && (addr == ADDR_W'(CTRL)))   ctrl   <= din[1:0];
      if (wren && (addr == ADDR_W'(EN)))     en     <= din[N_CNT-1:0];
      if (wren && (addr == ADDR_W'(OVF_IE))) ovf_ie <= din[N_CNT:0];
      ovf <= (ovf & ~ovf_clr) | wrap;
      irq <= |(ovf & ovf_ie);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= N_CNT; i++) snap[i] <= '0;
    end else if (snap_now) begin
      for (int i = 0; i <= N_CNT; i++) snap[i] <= cnt[i];
    end
  end

  always_comb begin
    rd_data = '0;
    if (addr == ADDR_W'(CTRL))     rd_data = 64'(ctrl);
    if (addr == ADDR_W'(EN))       rd_data = 64'(en);
    if (addr == ADDR_W'(OVF))      rd_data = 64'(ovf);
    if (addr == ADDR_W'(OVF_IE))   rd_data = 64'(ovf_ie);
    if (addr == ADDR_W'(CYCLE))    rd_data = cnt[N_CNT];
    if (addr == ADDR_W'(SNAP_CYC)) rd_data = snap[N_CNT];
    for (int i = 0; i < N_CNT; i++) begin
      if (addr == ADDR_W'(CNT_BASE + i))  rd_data = cnt[i];
      if (addr == ADDR_W'(SNAP_BASE + i)) rd_data = snap[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dout <= '0;
    else
      dout <= rd_data;
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank: directed scenarios plus random traffic,
// all checked against a register-level behavioural model.
module tb_perf_counter_bank;

  localparam int N_CNT = 8;
  localparam int ADDR_W = 6;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  logic [63:0] ain, din, dout;
  logic wren;
  logic [N_CNT-1:0] events;
  logic irq;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(.N_CNT(N_CNT), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .ain    (ain),
    .din    (din),
    .wren   (wren),
    .dout   (dout),
    .events (events),
    .irq    (irq)
  );

  // Model state; index N_CNT is the cycle counter.
  logic [63:0]      m_cnt  [N_CNT+1];
  logic [63:0]      m_snap [N_CNT+1];
  logic [1:0]       m_ctrl;
  logic [N_CNT-1:0] m_en;
  logic [N_CNT:0]   m_ovf, m_ie;
  logic [63:0]      exp_dout;
  logic             exp_irq;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i <= N_CNT; i++) begin
      m_cnt[i]  = '0;
      m_snap[i] = '0;
    end
    m_ctrl = '0; m_en = '0; m_ovf = '0; m_ie = '0;
    exp_dout = '0; exp_irq = 1'b0;
  endtask

  function automatic logic [63:0] model_read(input logic [63:0] a);
    int w;
    w = int'(a[5:0]);
    if (w == 0) return {62'd0, m_ctrl};
    if (w == 1) return 64'(m_en);
    if (w == 2) return 64'(m_ovf);
    if (w == 3) return 64'(m_ie);
    if (w == 5) return m_cnt[N_CNT];
    if (w >= 8 && w < 8 + N_CNT) return m_cnt[w-8];
    if (w >= 16 && w < 16 + N_CNT) return m_snap[w-16];
    if (w == 24) return m_snap[N_CNT];
    return 64'd0;
  endfunction

  function automatic logic [63:0] next_val(input logic [63:0] old, input bit bump, input bit wr,
                                           input logic [63:0] wv, input bit clr, output bit wrapped);
    wrapped = 1'b0;
    if (clr) return 64'd0;
    if (wr) return wv;
    if (bump) begin
      wrapped = (old == ONES);
      return old + 64'd1;
    end
    return old;
  endfunction

  // Advances the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    int w;
    bit run, clr, wrapped;
    logic [N_CNT:0] sets;
    logic [63:0] nxt [N_CNT+1];
    w = int'(ain[5:0]);
    exp_dout = model_read(ain);
    exp_irq = |(m_ovf & m_ie);
    run = m_ctrl[0] && !m_ctrl[1];
    clr = wren && w == 4 && din[0];
    sets = '0;
    for (int i = 0; i < N_CNT; i++) begin
      nxt[i] = next_val(m_cnt[i], run && events[i] && m_en[i], wren && w == 8 + i, din, clr, wrapped);
      sets[i] = wrapped;
    end
    nxt[N_CNT] = next_val(m_cnt[N_CNT], run, wren && w == 5, din, clr, wrapped);
    sets[N_CNT] = wrapped;
    if (wren && w == 4 && din[1])
      for (int i = 0; i <= N_CNT; i++) m_snap[i] = m_cnt[i];
    if (wren && w == 2) m_ovf = m_ovf & ~din[N_CNT:0];
    m_ovf = m_ovf | sets;
    if (wren && w == 0) m_ctrl = din[1:0];
    if (wren && w == 1) m_en = din[N_CNT-1:0];
    if (wren && w == 3) m_ie = din[N_CNT:0];
    for (int i = 0; i <= N_CNT; i++) m_cnt[i] = nxt[i];
  endtask

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] d, input bit we,
                               input logic [N_CNT-1:0] ev);
    @(negedge clk);
    ain = a; din = d; wren = we; events = ev;
    model_step();
    @(posedge clk);
    #1;
    checkOutput($sformatf("dout@%0h", a[5:0]), dout, exp_dout);
    checkOutput("irq", {63'd0, irq}, {63'd0, exp_irq});
  endtask

  task automatic readExpect(input logic [63:0] a, input logic [63:0] val, input string tag);
    applyStimulus(a, 64'd0, 1'b0, '0);
    checkOutput(tag, dout, val);
  endtask

  logic [63:0] hold0, hold_cyc, a_r, d_r;
  int w_r;

  initial begin
    rst = 1'b1; ain = '0; din = '0; wren = 1'b0; events = '0;
    model_reset();
    #12;
    checkOutput("rst_dout", dout, 64'd0);
    checkOutput("rst_irq", {63'd0, irq}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset contents of the whole map.
    for (int a = 0; a <= 24; a++) readExpect(64'(a), 64'd0, "reset_read");

    // Enabled counters follow events; cycle counter runs.
    applyStimulus(64'h0, 64'h1, 1'b1, '0);
    applyStimulus(64'h1, 64'h5, 1'b1, '0);
    for (int i = 0; i < 10; i++) applyStimulus(64'h0, 64'h0, 1'b0, 8'hFF);
    readExpect(64'h8, 64'd10, "cnt0_10");
    readExpect(64'h9, 64'd0, "cnt1_0");
    readExpect(64'hA, 64'd10, "cnt2_10");
    readExpect(64'h5, m_cnt[N_CNT], "cycle");

    // Counter 3 wraps, raises OVF[3] and irq; W1C drops irq a cycle later.
    applyStimulus(64'hB, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, '0);
    applyStimulus(64'h3, 64'h08, 1'b1, '0);
    applyStimulus(64'h1, 64'h08, 1'b1, '0);
    applyStimulus(64'h0, 64'h0, 1'b0, 8'h08);
    applyStimulus(64'h0, 64'h0, 1'b0, 8'h08);
    checkOutput("irq_not_yet", {63'd0, irq}, 64'd0);
    applyStimulus(64'h0, 64'h0, 1'b0, 8'h08);
    checkOutput("irq_rise", {63'd0, irq}, 64'd1);
    readExpect(64'hB, 64'd1, "cnt3_wrapped");
    readExpect(64'h2, 64'h08, "ovf3");
    applyStimulus(64'h2, 64'h08, 1'b1, '0);
    checkOutput("irq_still", {63'd0, irq}, 64'd1);
    applyStimulus(64'h0, 64'h0, 1'b0, '0);
    checkOutput("irq_fall", {63'd0, irq}, 64'd0);

    // Write beats increment; snapshot with clear keeps old values.
    applyStimulus(64'h1, 64'hFF, 1'b1, '0);
    applyStimulus(64'h8, 64'h100, 1'b1, 8'h01);
    readExpect(64'h8, 64'h100, "write_wins");
    applyStimulus(64'h4, 64'h3, 1'b1, 8'hFF);
    readExpect(64'h10, 64'h100, "snap0");
    readExpect(64'h13, 64'h1, "snap3");
    readExpect(64'h8, 64'h0, "cnt0_cleared");
    readExpect(64'h18, m_snap[N_CNT], "snap_cyc");

    // Wrap beats a simultaneous W1C of the same flag.
    applyStimulus(64'h9, ONES, 1'b1, '0);
    applyStimulus(64'h0, 64'h0, 1'b0, 8'h02);
    applyStimulus(64'h9, ONES, 1'b1, '0);
    applyStimulus(64'h2, 64'h02, 1'b1, 8'h02);
    readExpect(64'h2, 64'h02, "ovf_set_wins");

    // Freeze holds every counter.
    for (int i = 0; i < 3; i++) applyStimulus(64'h0, 64'h0, 1'b0, 8'hFF);
    applyStimulus(64'h0, 64'h3, 1'b1, 8'hFF);
    hold0 = m_cnt[0];
    hold_cyc = m_cnt[N_CNT];
    for (int i = 0; i < 5; i++) applyStimulus(64'h0, 64'h0, 1'b0, 8'hFF);
    readExpect(64'h8, hold0, "freeze_cnt0");
    readExpect(64'h5, hold_cyc, "freeze_cycle");

    // Asynchronous reset between edges.
    applyStimulus(64'h0, 64'h1, 1'b1, '0);
    applyStimulus(64'h3, 64'h1FF, 1'b1, 8'hFF);
    applyStimulus(64'h8, 64'h0, 1'b0, 8'hFF);
    applyStimulus(64'h8, 64'h0, 1'b0, 8'hFF);
    checkOutput("irq_pre_rst", {63'd0, irq}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_dout", dout, 64'd0);
    checkOutput("async_irq", {63'd0, irq}, 64'd0);
    model_reset();
    ain = '0; din = '0; wren = 1'b0; events = '0;
    @(negedge clk);
    rst = 1'b0;
    readExpect(64'h8, 64'd0, "post_rst_cnt0");
    readExpect(64'h0, 64'd0, "post_rst_ctrl");

    // Random traffic.
    applyStimulus(64'h0, 64'h1, 1'b1, '0);
    applyStimulus(64'h1, 64'hFF, 1'b1, '0);
    applyStimulus(64'h3, 64'h1FF, 1'b1, '0);
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 4))
        0: w_r = $urandom_range(0, 5);
        1: w_r = 8 + $urandom_range(0, 7);
        2: w_r = 16 + $urandom_range(0, 8);
        3: w_r = $urandom_range(0, 63);
        default: w_r = 2;
      endcase
      a_r = {$urandom, $urandom};
      a_r[5:0] = 6'(w_r);
      if ($urandom_range(0, 3) == 0) d_r = ONES - 64'($urandom_range(0, 3));
      else d_r = {$urandom, $urandom};
      if (w_r == 0) d_r = ($urandom_range(0, 3) != 0) ? 64'h1 : 64'($urandom_range(0, 3));
      if (w_r == 4 && $urandom_range(0, 3) != 0) d_r[0] = 1'b0;
      applyStimulus(a_r, d_r, $urandom_range(0, 9) < 3, 8'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
